// File: rtl/controlador_cruzamento_pkg.sv
// Shared definitions for the intersection controller: state codes, lamp
// encodings, default interval lengths and the state-to-lamp decoder.
package controlador_cruzamento_pkg;

  typedef enum logic [2:0] {
    VA  = 3'd0,
    AA  = 3'd1,
    LA  = 3'd2,
    PED = 3'd3,
    LP  = 3'd4,
    VB  = 3'd5,
    AB  = 3'd6,
    LB  = 3'd7
  } estado_t;

  localparam logic [2:0] VERMELHO = 3'b100;
  localparam logic [2:0] AMARELO  = 3'b010;
  localparam logic [2:0] VERDE    = 3'b001;

  localparam logic [7:0] T_VERDE_MIN_PADRAO = 8'd2;
  localparam logic [7:0] T_VERDE_MAX_PADRAO = 8'd5;
  localparam logic [7:0] T_AMARELO_PADRAO   = 8'd3;
  localparam logic [7:0] T_LIMPA_PADRAO     = 8'd1;
  localparam logic [7:0] T_PEDESTRE_PADRAO  = 8'd4;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       p;
  } lampadas_t;

  function automatic lampadas_t decodifica(input estado_t s);
    lampadas_t l;
    l = '{a: VERMELHO, b: VERMELHO, p: 1'b0};
    case (s)
      VA:      l.a = VERDE;
      AA:      l.a = AMARELO;
      VB:      l.b = VERDE;
      AB:      l.b = AMARELO;
      PED:     l.p = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/controlador_cruzamento_temporizador.sv
// 8-bit down-counter for the fixed-length intervals (yellow, clearance, walk).
// fim is high while the count is zero, i.e. on the last cycle of an interval.
module controlador_cruzamento_temporizador (
  input  logic       clk,
  input  logic       rst,
  input  logic       carrega,
  input  logic [7:0] valor,
  output logic       fim
);

  logic [7:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 8'd0;
    else if (carrega)
      cnt <= valor;
    else if (cnt != 8'd0)
      cnt <= cnt - 8'd1;
  end

  assign fim = (cnt == 8'd0);

endmodule

// File: rtl/controlador_cruzamento.sv
// Two-road intersection sequencer with a pedestrian phase; Moore lamp outputs
// decoded straight from the state register.
module controlador_cruzamento
  import controlador_cruzamento_pkg::*;
#(
  parameter logic [7:0] T_VERDE_MIN = T_VERDE_MIN_PADRAO,
  parameter logic [7:0] T_VERDE_MAX = T_VERDE_MAX_PADRAO,
  parameter logic [7:0] T_AMARELO   = T_AMARELO_PADRAO,
  parameter logic [7:0] T_LIMPA     = T_LIMPA_PADRAO,
  parameter logic [7:0] T_PEDESTRE  = T_PEDESTRE_PADRAO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensA,
  input  logic       sensB,
  input  logic       bt,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic       P,
  output logic       espera
);

  estado_t    estado, prox;
  logic [7:0] e;
  logic       ultima_b;
  logic       carrega;
  logic [7:0] valor_carga;
  logic       fim;
  logic       entra_ped, fica_ped;
  lampadas_t  lamp;

  controlador_cruzamento_temporizador u_temporizador (
    .clk     (clk),
    .rst     (rst),
    .carrega (carrega),
    .valor   (valor_carga),
    .fim     (fim)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the case statements can leave a value held and infer a latch.
  always_comb begin
    prox        = estado;
    carrega     = 1'b0;
    valor_carga = 8'd0;
    case (estado)
      VA:  if (e >= T_VERDE_MIN && (sensB || espera) && (!sensA || e >= T_VERDE_MAX))
             prox = AA;
      VB:  if (e >= T_VERDE_MIN && (sensA || espera) && (!sensB || e >= T_VERDE_MAX))
             prox = AB;
      AA:  if (fim) prox = LA;
      AB:  if (fim) prox = LB;
      LA:  if (fim) prox = espera ? PED : VB;
      LB:  if (fim) prox = espera ? PED : VA;
      PED: if (fim) prox = LP;
      LP:  if (fim) prox = ultima_b ? VA : VB;
      default: prox = VA;
    endcase

    // Timer is loaded with T-1 on entry so the state lasts exactly T cycles.
    if (prox != estado) begin
      case (prox)
        AA, AB:     begin carrega = 1'b1; valor_carga = T_AMARELO  - 8'd1; end
        LA, LB, LP: begin carrega = 1'b1; valor_carga = T_LIMPA    - 8'd1; end
        PED:        begin carrega = 1'b1; valor_carga = T_PEDESTRE - 8'd1; end
        default: ;
      endcase
    end
  end

  assign entra_ped = (prox == PED) && (estado != PED);
  assign fica_ped  = (prox == PED) && (estado == PED);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= VA;
      e        <= 8'd1;
      espera   <= 1'b0;
      ultima_b <= 1'b0;
    end else begin
      estado <= prox;
      if (prox != estado)
        e <= 8'd1;
      else if (e != 8'hFF)
        e <= e + 8'd1;

      // A press on the edge that enters the walk is absorbed by it; presses
      // during the walk are ignored, but the exit edge latches again.
      if (entra_ped)
        espera <= 1'b0;
      else if (!fica_ped && bt)
        espera <= 1'b1;

      if (estado == LA && prox != LA)
        ultima_b <= 1'b0;
      else if (estado == LB && prox != LB)
        ultima_b <= 1'b1;
    end
  end

  assign lamp = decodifica(estado);
  assign A    = lamp.a;
  assign B    = lamp.b;
  assign P    = lamp.p;

endmodule

// File: tb/tb_controlador_cruzamento.sv
// Bench for controlador_cruzamento: directed literal scenarios plus randomized
// traffic checked every cycle against a phase/age model of the controller.
module tb_controlador_cruzamento;

  localparam int MIN_V = 2, MAX_V = 5, T_AM = 3, T_LI = 1, T_PE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0, sensA = 1'b0, sensB = 1'b0, bt = 1'b0;
  logic [2:0] A, B;
  logic       P, espera;

  int errors = 0;
  int checks = 0;

  controlador_cruzamento dut (
    .clk(clk), .rst(rst), .sensA(sensA), .sensB(sensB), .bt(bt),
    .A(A), .B(B), .P(P), .espera(espera)
  );

  always #5 clk = ~clk;

  task automatic check(input string nome, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b expected %b", nome, $time, got, exp);
    end
  endtask

  // Model: phase index, age in phase (1 on entry), pending request, last road.
  localparam int VERDE_A = 0, AMAR_A = 1, LIMPA_A = 2, TRAVESSIA = 3,
                 LIMPA_P = 4, VERDE_B = 5, AMAR_B = 6, LIMPA_B = 7;
  int         dur    [8] = '{0, T_AM, T_LI, T_PE, T_LI, 0, T_AM, T_LI};
  logic [2:0] lamp_a [8] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] lamp_b [8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int fase = 0, idade = 1;
  bit pend = 0, ult_b = 0, valido = 0;

  always @(posedge clk) begin
    int nf;
    bit own, other;
    if (rst) begin
      fase = VERDE_A; idade = 1; pend = 0; ult_b = 0; valido = 1;
    end else if (valido) begin
      nf = fase;
      if (fase == VERDE_A || fase == VERDE_B) begin
        own   = (fase == VERDE_A) ? sensA : sensB;
        other = (fase == VERDE_A) ? sensB : sensA;
        if (idade >= MIN_V && (other || pend) && (!own || idade >= MAX_V))
          nf = fase + 1;
      end else if (idade >= dur[fase]) begin
        case (fase)
          LIMPA_A: begin nf = pend ? TRAVESSIA : VERDE_B; ult_b = 0; end
          LIMPA_B: begin nf = pend ? TRAVESSIA : VERDE_A; ult_b = 1; end
          LIMPA_P: nf = ult_b ? VERDE_A : VERDE_B;
          default: nf = fase + 1;
        endcase
      end
      if (nf == TRAVESSIA && fase != TRAVESSIA) pend = 0;
      else if (!(nf == TRAVESSIA && fase == TRAVESSIA) && bt) pend = 1;
      idade = (nf != fase) ? 1 : (idade < 255 ? idade + 1 : 255);
      fase = nf;
    end
  end

  always @(negedge clk) begin
    if (valido) begin
      check("model_A", A, lamp_a[fase]);
      check("model_B", B, lamp_b[fase]);
      check("model_P", {2'b0, P}, {2'b0, fase == TRAVESSIA});
      check("model_espera", {2'b0, espera}, {2'b0, pend});
    end
  end

  task automatic borda();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1; sensA = 0; sensB = 0; bt = 0;
    borda();
    rst = 0;
  endtask

  // Expected lamps after edges 1..8 with sensB held, and after edges 1..11
  // for the pedestrian scenario.
  logic [2:0] sb_a [8]  = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] sb_b [8]  = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001};
  logic [2:0] pd_a [11] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100,
                            3'b100, 3'b100, 3'b100};
  logic [2:0] pd_b [11] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                            3'b100, 3'b100, 3'b001};
  logic       pd_p [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  logic       pd_e [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};

  initial begin
    int pa, pb;

    // Idle after reset.
    reset_dut();
    repeat (50) begin
      borda();
      check("idle_A", A, 3'b001);
      check("idle_B", B, 3'b100);
      check("idle_P", {2'b0, P}, 3'b000);
      check("idle_espera", {2'b0, espera}, 3'b000);
    end

    // Only road B demands: A yields after minimum green, B then rests.
    reset_dut();
    sensB = 1;
    for (int i = 0; i < 8; i++) begin
      borda();
      check("sensB_A", A, sb_a[i]);
      check("sensB_B", B, sb_b[i]);
    end

    // Pedestrian: press absorbed on PED entry, ignored during walk, latched on exit.
    reset_dut();
    for (int i = 1; i <= 11; i++) begin
      bt = (i inside {1, 6, 7, 8, 10});
      borda();
      bt = 0;
      check("ped_A", A, pd_a[i-1]);
      check("ped_B", B, pd_b[i-1]);
      check("ped_P", {2'b0, P}, {2'b0, pd_p[i-1]});
      check("ped_espera", {2'b0, espera}, {2'b0, pd_e[i-1]});
    end

    // Both sensors held: maximum green, then reset during AB.
    reset_dut();
    sensA = 1; sensB = 1;
    for (int i = 1; i <= 14; i++) begin
      bt = (i == 12);
      borda();
      bt = 0;
      if (i == 4)  check("max_va_last", A, 3'b001);
      if (i == 5)  check("max_aa_first", A, 3'b010);
      if (i == 8)  check("max_la", {A[2], B[2], 1'b0}, 3'b110);
      if (i == 9)  check("max_vb_first", B, 3'b001);
      if (i == 13) check("max_vb_last", B, 3'b001);
      if (i == 14) begin
        check("max_ab_first", B, 3'b010);
        check("max_espera_set", {2'b0, espera}, 3'b001);
      end
    end
    rst = 1;
    borda();
    rst = 0;
    check("rst_ab_A", A, 3'b001);
    check("rst_ab_B", B, 3'b100);
    check("rst_ab_espera", {2'b0, espera}, 3'b000);
    repeat (4) borda();
    check("rst_green_restart_last", A, 3'b001);
    borda();
    check("rst_green_restart_exit", A, 3'b010);

    // Randomized traffic with occasional resets.
    pa = 50; pb = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        pa = $urandom_range(0, 3) * 33;
        pb = $urandom_range(0, 3) * 33;
      end
      sensA = ($urandom_range(0, 99) < pa);
      sensB = ($urandom_range(0, 99) < pb);
      bt    = ($urandom_range(0, 99) < 4);
      rst   = ($urandom_range(0, 499) == 0);
      borda();
    end
    rst = 0; bt = 0;
    borda();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
